// File: rtl/inst_loader.sv
// Host-to-instruction-memory loader: pairs 32-bit host words into 64-bit BPF instructions.
// Define INST_LOADER_OVF_ERR_EN to flag and drop overflowing instructions instead of wrapping.
module inst_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic                  cpu_busy,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_en,
  output logic                  loading,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   prog_len,
  output logic                  err,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state;
  logic [31:0]         hi_word;
  logic [ADDR_WIDTH:0] cnt;
  logic [ADDR_WIDTH:0] cnt_inc;
  logic                hs;
  logic                ovf;

  // Handshake: a word moves only when s_valid && s_ready at a rising edge.
  // s_ready depends on state, cpu_busy and rst only, never on s_valid.
  always_comb begin
    s_ready = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    s_ready = !cpu_busy;
        LO, HI:  s_ready = 1'b1;
        default: s_ready = 1'b0;
      endcase
    end
  end

  assign hs        = s_valid && s_ready;
  assign dbg_state = state;

  // Overflow: completing an instruction while the count already equals the depth.
  always_comb begin
    ovf     = (cnt == {1'b1, {ADDR_WIDTH{1'b0}}});
    cnt_inc = cnt + 1'b1;
`ifdef INST_LOADER_OVF_ERR_EN
    if (ovf) cnt_inc = cnt;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hi_word   <= '0;
      cnt       <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_en     <= 1'b0;
      loading   <= 1'b0;
      load_done <= 1'b0;
      prog_len  <= '0;
      err       <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (hs) begin
            hi_word <= s_data;
            cnt     <= '0;
            loading <= 1'b1;
            err     <= s_last;
            if (s_last) begin
              state     <= DONE;
              load_done <= 1'b1;
              prog_len  <= '0;
            end else begin
              state <= LO;
            end
          end
        end
        LO: begin
          if (hs) begin
`ifdef INST_LOADER_OVF_ERR_EN
            if (ovf) begin
              err <= 1'b1;
            end else begin
              wr_en   <= 1'b1;
              wr_addr <= cnt[ADDR_WIDTH-1:0];
              wr_data <= {hi_word, s_data};
            end
`else
            // Truncating the count wraps the write address back to 0 past the top.
            wr_en   <= 1'b1;
            wr_addr <= cnt[ADDR_WIDTH-1:0];
            wr_data <= {hi_word, s_data};
`endif
            cnt <= cnt_inc;
            if (s_last) begin
              state     <= DONE;
              load_done <= 1'b1;
              prog_len  <= cnt_inc;
            end else begin
              state <= HI;
            end
          end
        end
        HI: begin
          if (hs) begin
            hi_word <= s_data;
            if (s_last) begin
              // Odd trailing word: discarded, load flagged as malformed.
              err       <= 1'b1;
              state     <= DONE;
              load_done <= 1'b1;
              prog_len  <= cnt;
            end else begin
              state <= LO;
            end
          end
        end
        default: begin
          loading <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: a full-size instance plus an ADDR_WIDTH=2 instance
// sharing the same host stream, the small one used for the overflow case.
module tb_inst_loader;

  localparam int AW  = 10;
  localparam int SAW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       s_data;
  logic              s_valid;
  logic              s_last;
  logic              cpu_busy;

  logic              s_ready;
  logic [AW-1:0]     wr_addr;
  logic [63:0]       wr_data;
  logic              wr_en;
  logic              loading;
  logic              load_done;
  logic [AW:0]       prog_len;
  logic              err;
  logic [1:0]        dbg_state;

  logic              sm_s_ready;
  logic [SAW-1:0]    sm_wr_addr;
  logic [63:0]       sm_wr_data;
  logic              sm_wr_en;
  logic              sm_loading;
  logic              sm_load_done;
  logic [SAW:0]      sm_prog_len;
  logic              sm_err;
  logic [1:0]        sm_dbg_state;

  int checks = 0;
  int errors = 0;
  bit small_mon = 1'b0;

  logic [AW+63:0]  exp_q[$];
  logic [SAW+63:0] exp_s_q[$];

  inst_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(64)) u_dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .cpu_busy(cpu_busy), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_en(wr_en), .loading(loading), .load_done(load_done), .prog_len(prog_len),
    .err(err), .dbg_state(dbg_state)
  );

  inst_loader #(.ADDR_WIDTH(SAW), .DATA_WIDTH(64)) u_small (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(sm_s_ready), .cpu_busy(cpu_busy), .wr_addr(sm_wr_addr), .wr_data(sm_wr_data),
    .wr_en(sm_wr_en), .loading(sm_loading), .load_done(sm_load_done), .prog_len(sm_prog_len),
    .err(sm_err), .dbg_state(sm_dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboards: every memory write must match the head of the expected queue.
  always @(negedge clk) begin
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 80'(wr_en), 80'(0));
      end else begin
        logic [AW+63:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 80'(wr_addr), 80'(e[AW+63:64]));
        check("wr_data", 80'(wr_data), 80'(e[63:0]));
      end
    end
    if (small_mon && sm_wr_en) begin
      if (exp_s_q.size() == 0) begin
        check("sm_unexpected_write", 80'(sm_wr_en), 80'(0));
      end else begin
        logic [SAW+63:0] e;
        e = exp_s_q.pop_front();
        check("sm_wr_addr", 80'(sm_wr_addr), 80'(e[SAW+63:64]));
        check("sm_wr_data", 80'(sm_wr_data), 80'(e[63:0]));
      end
    end
  end

  // Driver: called at a falling edge; returns at the falling edge after the handshake.
  task automatic send_word(input logic [31:0] d, input bit last, input bit wr_exp, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    s_data  = d;
    s_last  = last;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("handshake_timeout", 80'(s_ready), 80'(1));
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("wr_en_latency", 80'(wr_en), 80'(wr_exp));
  endtask

  // Called at the DONE-cycle falling edge, right after the last-word handshake.
  task automatic end_load(input int len, input bit e);
    check("load_done", 80'(load_done), 80'(1));
    check("prog_len", 80'(prog_len), 80'(len));
    check("err", 80'(err), 80'(e));
    check("loading_in_done", 80'(loading), 80'(1));
    check("state_done", 80'(dbg_state), 80'(3));
    @(negedge clk);
    check("loading_fall", 80'(loading), 80'(0));
    check("load_done_pulse", 80'(load_done), 80'(0));
    check("scoreboard_drain", 80'(exp_q.size()), 80'(0));
  endtask

  initial begin
    logic [31:0] hw;
    logic [31:0] lw;

    rst      = 1'b1;
    s_data   = '0;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    cpu_busy = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_s_ready", 80'(s_ready), 80'(0));
    check("rst_wr_en", 80'(wr_en), 80'(0));
    check("rst_wr_addr", 80'(wr_addr), 80'(0));
    check("rst_wr_data", 80'(wr_data), 80'(0));
    check("rst_loading", 80'(loading), 80'(0));
    check("rst_load_done", 80'(load_done), 80'(0));
    check("rst_prog_len", 80'(prog_len), 80'(0));
    check("rst_err", 80'(err), 80'(0));
    rst = 1'b0;
    @(negedge clk);
    check("idle_s_ready", 80'(s_ready), 80'(1));

    // Two-instruction program
    exp_q.push_back({10'd0, 64'h0028_0000_0000_000C});
    send_word(32'h0028_0000, 1'b0, 1'b0, 0);
    check("loading_rise", 80'(loading), 80'(1));
    send_word(32'h0000_000C, 1'b0, 1'b1, 0);
    exp_q.push_back({10'd1, 64'h0015_0000_0000_0800});
    send_word(32'h0015_0000, 1'b0, 1'b0, 0);
    send_word(32'h0000_0800, 1'b1, 1'b1, 0);
    end_load(2, 1'b0);

    // cpu_busy holds off a new load; ignored once the load has begun
    cpu_busy = 1'b1;
    s_data   = 32'h1111_2222;
    s_last   = 1'b0;
    s_valid  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("busy_s_ready", 80'(s_ready), 80'(0));
      check("busy_state", 80'(dbg_state), 80'(0));
      check("busy_loading", 80'(loading), 80'(0));
    end
    cpu_busy = 1'b0;
    #1;
    check("unbusy_s_ready", 80'(s_ready), 80'(1));
    @(posedge clk);
    @(negedge clk);
    s_valid  = 1'b0;
    check("unbusy_state_lo", 80'(dbg_state), 80'(1));
    check("unbusy_loading", 80'(loading), 80'(1));
    cpu_busy = 1'b1;
    exp_q.push_back({10'd0, 64'h1111_2222_3333_4444});
    send_word(32'h3333_4444, 1'b1, 1'b1, 0);
    cpu_busy = 1'b0;
    end_load(1, 1'b0);

    // Odd word count: trailing word dropped, err set, cleared by next load
    exp_q.push_back({10'd0, 64'hAAAA_0001_BBBB_0002});
    send_word(32'hAAAA_0001, 1'b0, 1'b0, 0);
    send_word(32'hBBBB_0002, 1'b0, 1'b1, 0);
    send_word(32'hCCCC_0003, 1'b1, 1'b0, 0);
    end_load(1, 1'b1);
    send_word(32'hDDDD_0004, 1'b0, 1'b0, 0);
    check("err_cleared", 80'(err), 80'(0));
    exp_q.push_back({10'd0, 64'hDDDD_0004_EEEE_0005});
    send_word(32'hEEEE_0005, 1'b1, 1'b1, 0);
    end_load(1, 1'b0);

    // Single word with s_last: empty, malformed program
    send_word(32'h0BAD_0BAD, 1'b1, 1'b0, 0);
    end_load(0, 1'b1);

    // 16 instructions with random valid gaps
    for (int i = 0; i < 16; i++) begin
      hw = 32'hA000_0000 + 32'(i);
      lw = 32'h0000_5000 + 32'(i);
      exp_q.push_back({10'(i), hw, lw});
      send_word(hw, 1'b0, 1'b0, int'($urandom_range(0, 1)));
      send_word(lw, (i == 15), 1'b1, int'($urandom_range(0, 1)));
    end
    end_load(16, 1'b0);

    // Overflow on the ADDR_WIDTH=2 instance (depth 4), 5 instructions
    small_mon = 1'b1;
    for (int i = 0; i < 5; i++) begin
      hw = 32'h5000_0000 + 32'(i);
      lw = 32'h0600_0000 + 32'(i);
      exp_q.push_back({10'(i), hw, lw});
`ifdef INST_LOADER_OVF_ERR_EN
      if (i < 4) exp_s_q.push_back({2'(i), hw, lw});
`else
      exp_s_q.push_back({2'(i % 4), hw, lw});
`endif
      send_word(hw, 1'b0, 1'b0, 0);
      send_word(lw, (i == 4), 1'b1, 0);
    end
    check("sm_load_done", 80'(sm_load_done), 80'(1));
`ifdef INST_LOADER_OVF_ERR_EN
    check("sm_prog_len", 80'(sm_prog_len), 80'(4));
    check("sm_err", 80'(sm_err), 80'(1));
`else
    check("sm_prog_len", 80'(sm_prog_len), 80'(5));
    check("sm_err", 80'(sm_err), 80'(0));
`endif
    end_load(5, 1'b0);
    check("sm_scoreboard_drain", 80'(exp_s_q.size()), 80'(0));
    small_mon = 1'b0;

    // Reset mid-instruction: partial instruction must never be written
    send_word(32'h7777_0000, 1'b0, 1'b0, 0);
    check("pre_rst_state_lo", 80'(dbg_state), 80'(1));
    rst     = 1'b1;
    s_data  = 32'h8888_0000;
    s_valid = 1'b1;
    #1;
    check("rst_mid_s_ready", 80'(s_ready), 80'(0));
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_state", 80'(dbg_state), 80'(0));
    check("rst_mid_wr_en", 80'(wr_en), 80'(0));
    check("rst_mid_loading", 80'(loading), 80'(0));
    check("rst_mid_prog_len", 80'(prog_len), 80'(0));
    rst     = 1'b0;
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_no_write", 80'(exp_q.size()), 80'(0));

    // Recovery load after reset
    exp_q.push_back({10'd0, 64'h9999_0000_AAAA_0000});
    send_word(32'h9999_0000, 1'b0, 1'b0, 0);
    send_word(32'hAAAA_0000, 1'b1, 1'b1, 0);
    end_load(1, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
# inst_loader

Upstream feeder for the instruction memory. Accepts a program from the host as a stream of 32-bit words over a valid/ready handshake, pairs consecutive words into 64-bit BPF instructions (high word first), and drives the memory's write port (`wr_addr`/`wr_data`/`wr_en`) at sequential addresses from 0. Reports program length and completion, holds off the CPU while a load is in progress, and flags malformed or oversized programs.

## Interface
- `ADDR_WIDTH`, 10: instruction memory address width; depth = 2**ADDR_WIDTH.
- `DATA_WIDTH`, 64: instruction width; fixed at 64 (two 32-bit words).

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_data`  in  32  host word.
- `s_valid`  in  1  `s_data` valid.
- `s_last`  in  1  final word of program; qualified by `s_valid`.
- `s_ready`  out  1  loader accepts word this cycle.
- `cpu_busy`  in  1  CPU executing; a new load may not begin while high.
- `wr_addr`  out  ADDR_WIDTH  memory write address.
- `wr_data`  out  DATA_WIDTH  memory write data, `{hi_word, lo_word}`.
- `wr_en`  out  1  memory write strobe.
- `loading`  out  1  load in progress; CPU must not start while high.
- `load_done`  out  1  one-cycle pulse at end of load.
- `prog_len`  out  ADDR_WIDTH+1  instructions written by the last completed load.
- `err`  out  1  sticky error for the last load; cleared when the next load begins.

## Operation
- Handshake occurs when `s_valid && s_ready`. Words are accepted only on handshake.
- States:
  - IDLE: `s_ready = !cpu_busy`. On handshake: capture `hi`, clear `err`, set word address to 0, set `loading`, then go to LO. If `s_last` is also high, set `err` and go to DONE.
  - LO: `s_ready = 1`. On handshake: register a write of `{hi, s_data}` at the current address and increment the address. If `s_last`, go to DONE; otherwise go to HI.
  - HI: `s_ready = 1`. On handshake: capture `hi` and go to LO. If `s_last`, the odd trailing word is discarded, `err` is set, and the next state is DONE.
  - DONE: `s_ready = 0`. Pulse `load_done`, latch `prog_len` from the address count, then go to IDLE.
- `loading` is high from the first handshake through the DONE cycle, inclusive.
- Address count is ADDR_WIDTH+1 bits, so a full memory of 2**ADDR_WIDTH instructions is representable. Overflow means completing an instruction when the count already equals the depth; handling is set by the configuration macro.
- `cpu_busy` is sampled only in IDLE. It has no effect once a load has begun.
- `rst` in any state: return to IDLE and drop any partial instruction. Memory contents already written are left unchanged.

## Timing
- Reset values: `s_ready` 0 while `rst` is high, `wr_en` 0, `wr_addr` 0, `wr_data` 0, `loading` 0, `load_done` 0, `prog_len` 0, `err` 0.
- `s_ready` is a combinational function of state and `cpu_busy` only, never of `s_valid`.
- A handshake in LO at cycle N gives `wr_en` = 1 with the corresponding `wr_addr`/`wr_data` during cycle N+1. `wr_en` is low in all other cycles.
- A last-word handshake at cycle N gives DONE at N+1, with `load_done` = 1 and `prog_len` valid. The final write also lands in N+1, so the memory is consistent from N+2, when `loading` falls.
- Maximum throughput is one word per cycle, i.e. one instruction per 2 cycles.
- At least one idle cycle (DONE) separates back-to-back loads.

## Configuration
- `INST_LOADER_OVF_ERR_EN` defined: overflowing instructions are not written (`wr_en` stays low), `err` is set, the address saturates at depth, and the load continues consuming words until `s_last`.
- Undefined: on overflow the address wraps to 0 and writes continue (overwriting from address 0), no error is flagged, and `prog_len` reports the count modulo 2**(ADDR_WIDTH+1).

## Test plan
- Load 4 words 0x00280000,0x0000000C,0x00150000,0x00000800 (last on 4th) -> writes 0x002800000000000C @0 and 0x0015000000000800 @1, each one cycle after its low-word handshake. `load_done` pulses, `prog_len`=2, `err`=0.
- `cpu_busy`=1 with `s_valid`=1 in IDLE -> `s_ready`=0 and no state change. Drop `cpu_busy` -> the first word is accepted that cycle.
- 3 words with `s_last` on the 3rd -> one write @0, the 3rd word is discarded, `err`=1, `prog_len`=1. The next load's first handshake clears `err`.
- Random `s_valid` gaps (≈50%) over a 16-instruction load -> writes at addresses 0..15 in order with correct data, `prog_len`=16.
- ADDR_WIDTH=2, 5 instructions: with `INST_LOADER_OVF_ERR_EN`, 4 writes, `err`=1, `prog_len`=4. Without it, the 5th write goes @0, `err`=0, `prog_len`=5.
- Assert `rst` in LO after a high-word handshake -> next cycle IDLE, `wr_en`=0, `loading`=0, and no write of the partial instruction.
